// File: rtl/bipolar_bitserial_driver_pkg.sv
// bipolar_bitserial_driver_pkg: state encoding, plane index sizing and precision clamp shared by the driver files
package bipolar_bitserial_driver_pkg;
  localparam int DEF_IN_BITS = 8;
  localparam int DEF_NUM_LANES = 32;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int idx_width(input int in_bits);
    return ($clog2(in_bits) > 4) ? $clog2(in_bits) : 4;
  endfunction
  // index of the final plane; out-of-range precisions fall back to the full width
  function automatic int last_plane(input logic [3:0] ib, input int in_bits);
    return (ib == 4'd0 || int'(ib) > in_bits) ? in_bits - 1 : int'(ib) - 1;
  endfunction
endpackage

// File: rtl/bipolar_bitserial_driver_if.sv
// bipolar_bitserial_driver_if: vector-in / plane-out handshake bundle; slave is the driver, master the surroundings
interface bipolar_bitserial_driver_if
  import bipolar_bitserial_driver_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NUM_LANES = DEF_NUM_LANES
);
  localparam int IDX_W = idx_width(IN_BITS);
  logic in_valid;
  logic in_ready;
  logic [NUM_LANES-1:0][IN_BITS-1:0] bipolar_p;
  logic [NUM_LANES-1:0][IN_BITS-1:0] bipolar_n;
  logic [3:0] input_bits;
  logic [NUM_LANES-1:0] wl_p;
  logic [NUM_LANES-1:0] wl_n;
  logic plane_valid;
  logic plane_ready;
  logic [IDX_W-1:0] plane_idx;
  logic plane_last;
  logic busy;
  modport slave (
    input in_valid, bipolar_p, bipolar_n, input_bits, plane_ready,
    output in_ready, wl_p, wl_n, plane_valid, plane_idx, plane_last, busy
  );
  modport master (
    output in_valid, bipolar_p, bipolar_n, input_bits, plane_ready,
    input in_ready, wl_p, wl_n, plane_valid, plane_idx, plane_last, busy
  );
endinterface

// File: rtl/bipolar_bitserial_driver_bitplane_select.sv
// bipolar_bitserial_driver_bitplane_select: picks bit-plane k across all lanes; with BITSERIAL_ZERO_SKIP_EN
// it also flags which planes carry any set bit
module bipolar_bitserial_driver_bitplane_select #(
  parameter int IN_BITS = 8,
  parameter int NUM_LANES = 32
) (
  input  logic [NUM_LANES-1:0][IN_BITS-1:0] p,
  input  logic [NUM_LANES-1:0][IN_BITS-1:0] n,
  input  logic [$clog2(IN_BITS)-1:0]        k,
  output logic [NUM_LANES-1:0]              plane_p,
  output logic [NUM_LANES-1:0]              plane_n
`ifdef BITSERIAL_ZERO_SKIP_EN
  ,
  output logic [IN_BITS-1:0]                nz
`endif
);
  logic [IN_BITS-1:0][NUM_LANES-1:0] tp, tn;
  for (genvar b = 0; b < IN_BITS; b++) begin : g_plane
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      assign tp[b][l] = p[l][b];
      assign tn[b][l] = n[l][b];
    end
`ifdef BITSERIAL_ZERO_SKIP_EN
    assign nz[b] = |{tp[b], tn[b]};
`endif
  end
  assign plane_p = tp[k];
  assign plane_n = tn[k];
endmodule

// File: rtl/bipolar_bitserial_driver.sv
// bipolar_bitserial_driver: captures a bipolar p/n vector and streams it LSB plane first as wordline bits.
// Define BITSERIAL_ZERO_SKIP_EN to skip all-zero planes (the final plane is always emitted).
module bipolar_bitserial_driver
  import bipolar_bitserial_driver_pkg::*;
#(
  parameter int IN_BITS = DEF_IN_BITS,
  parameter int NUM_LANES = DEF_NUM_LANES
) (
  input logic clk,
  input logic nrst,
  bipolar_bitserial_driver_if.slave bus
);
  localparam int IDX_W = idx_width(IN_BITS);
  localparam int SW = $clog2(IN_BITS);
  state_t state, nxt_state;
  logic [NUM_LANES-1:0][IN_BITS-1:0] p_reg, n_reg, src_p, src_n;
  logic [NUM_LANES-1:0] sel_p, sel_n, wl_p, wl_n;
  logic [IDX_W-1:0] idx, last_q, nxt_idx, nxt_last, seek;
  logic in_ready, plane_valid, acc, fire, done;
  int start;
`ifdef BITSERIAL_ZERO_SKIP_EN
  logic [IN_BITS-1:0] nz;
`endif
  assign acc = bus.in_valid && in_ready;
  assign fire = plane_valid && bus.plane_ready;
  assign done = fire && idx == last_q;
  // on accept the plane logic looks straight at the incoming vector so the first plane lands one cycle later
  assign src_p = acc ? bus.bipolar_p : p_reg;
  assign src_n = acc ? bus.bipolar_n : n_reg;
  bipolar_bitserial_driver_bitplane_select #(
    .IN_BITS(IN_BITS),
    .NUM_LANES(NUM_LANES)
  ) u_select (
    .p(src_p),
    .n(src_n),
    .k(nxt_idx[SW-1:0]),
    .plane_p(sel_p),
    .plane_n(sel_n)
`ifdef BITSERIAL_ZERO_SKIP_EN
    ,
    .nz(nz)
`endif
  );
  always_comb begin
    nxt_last = acc ? IDX_W'(last_plane(bus.input_bits, IN_BITS)) : last_q;
    nxt_state = acc ? STREAM : done ? IDLE : state;
    start = acc ? 0 : int'(idx) + 1;
    seek = IDX_W'(start);
`ifdef BITSERIAL_ZERO_SKIP_EN
    seek = nxt_last;
    for (int j = IN_BITS - 1; j >= 0; j--)
      seek = (j >= start && j < int'(nxt_last) && nz[j]) ? IDX_W'(j) : seek;
`endif
    nxt_idx = done ? '0 : (acc || fire) ? seek : idx;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) state <= IDLE;
    else state <= nxt_state;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      in_ready <= 1'b0;
      plane_valid <= 1'b0;
      idx <= '0;
      last_q <= '0;
      wl_p <= '0;
      wl_n <= '0;
      p_reg <= '0;
      n_reg <= '0;
    end else begin
      in_ready <= nxt_state == IDLE;
      plane_valid <= nxt_state == STREAM;
      idx <= nxt_idx;
      last_q <= nxt_last;
      wl_p <= nxt_state == STREAM ? sel_p : '0;
      wl_n <= nxt_state == STREAM ? sel_n : '0;
      p_reg <= src_p;
      n_reg <= src_n;
    end
  assign bus.in_ready = in_ready;
  assign bus.plane_valid = plane_valid;
  assign bus.plane_idx = idx;
  assign bus.wl_p = wl_p;
  assign bus.wl_n = wl_n;
  assign bus.plane_last = plane_valid && idx == last_q;
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_bipolar_bitserial_driver.sv
// tb_bipolar_bitserial_driver: randomized scenarios against a plane-list reference model of the bit-serial driver
module tb_bipolar_bitserial_driver;
  localparam int NL = 4;
  localparam int IB = 8;
`ifdef BITSERIAL_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct {
    int idx;
    logic [NL-1:0] wp;
    logic [NL-1:0] wn;
    bit last;
  } plane_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [NL-1:0][IB-1:0] cur_p, cur_n;
  plane_t exp_q[$];
  bipolar_bitserial_driver_if #(.IN_BITS(IB), .NUM_LANES(NL)) bus ();
  bipolar_bitserial_driver #(.IN_BITS(IB), .NUM_LANES(NL)) dut (
    .clk(clk),
    .nrst(nrst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // expected planes: bit k of every magnitude for k below the clamped precision
  function automatic void build_model(input logic [3:0] ib);
    int nb;
    plane_t e;
    nb = (ib == 4'd0 || int'(ib) > IB) ? IB : int'(ib);
    exp_q.delete();
    for (int k = 0; k < nb; k++) begin
      for (int l = 0; l < NL; l++) begin
        e.wp[l] = ((int'(cur_p[l]) / (2 ** k)) % 2) == 1;
        e.wn[l] = ((int'(cur_n[l]) / (2 ** k)) % 2) == 1;
      end
      e.idx = k;
      e.last = (k == nb - 1);
      if (!SKIP || e.last || e.wp != '0 || e.wn != '0) exp_q.push_back(e);
    end
  endfunction
  task automatic rand_vec;
    logic [IB-1:0] mask, mag;
    int s;
    mask = IB'($urandom_range(0, 255));
    for (int l = 0; l < NL; l++) begin
      mag = IB'($urandom_range(0, 255)) & mask;
      s = $urandom_range(0, 7);
      cur_p[l] = s < 4 ? mag : s == 7 ? IB'($urandom_range(0, 255)) : '0;
      cur_n[l] = s >= 4 ? mag : '0;
    end
  endtask
  // mode 0: always ready, 1: three stall cycles at plane 1, 2: random stalls plus upstream noise
  task automatic run_vec(input logic [3:0] ib, input int mode, input bit chg, output int nplanes);
    int stalls, scnt;
    bit held, ready, done;
    logic [3:0] pidx;
    logic [NL-1:0] pwp, pwn;
    stalls = 0;
    scnt = 0;
    held = 0;
    done = 0;
    nplanes = 0;
    pidx = '0;
    pwp = '0;
    pwn = '0;
    build_model(ib);
    for (int c = 0; c < 20 && !bus.in_ready; c++) step;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%b required 1", bus.in_ready);
      return;
    end
    bus.in_valid = 1'b1;
    bus.bipolar_p = cur_p;
    bus.bipolar_n = cur_n;
    bus.input_bits = ib;
    step;
    bus.in_valid = 1'b0;
    bus.bipolar_p = (NL * IB)'($urandom);
    for (int c = 0; c < 200 && !done; c++) begin
      if (bus.in_ready === 1'b1) begin
        done = 1;
        checks++;
        if (exp_q.size() != 0 || c != nplanes + stalls || bus.plane_valid !== 1'b0 ||
            bus.wl_p !== '0 || bus.wl_n !== '0 || bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL stream_end: cycle=%0d left=%0d valid=%b busy=%b wl_p=%b wl_n=%b, required cycle=%0d left=0 idle zeros",
                   c, exp_q.size(), bus.plane_valid, bus.busy, bus.wl_p, bus.wl_n, nplanes + stalls);
        end
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_plane: idx=%0d valid=%b, required no further plane", bus.plane_idx, bus.plane_valid);
        end else if (bus.plane_valid !== 1'b1 || bus.busy !== 1'b1 || bus.plane_idx !== 4'(exp_q[0].idx) ||
                     bus.wl_p !== exp_q[0].wp || bus.wl_n !== exp_q[0].wn || bus.plane_last !== exp_q[0].last) begin
          errors++;
          $display("FAIL plane: got v=%b busy=%b idx=%0d p=%b n=%b last=%b, required v=1 busy=1 idx=%0d p=%b n=%b last=%b",
                   bus.plane_valid, bus.busy, bus.plane_idx, bus.wl_p, bus.wl_n, bus.plane_last,
                   exp_q[0].idx, exp_q[0].wp, exp_q[0].wn, exp_q[0].last);
        end
        if (held) begin
          checks++;
          if ({pidx, pwp, pwn} !== {bus.plane_idx, bus.wl_p, bus.wl_n}) begin
            errors++;
            $display("FAIL stall_hold: idx=%0d p=%b n=%b, required idx=%0d p=%b n=%b",
                     bus.plane_idx, bus.wl_p, bus.wl_n, pidx, pwp, pwn);
          end
        end
        ready = mode == 0 ? 1'b1 : mode == 1 ? !(bus.plane_idx == 4'd1 && scnt < 3) : $urandom_range(0, 3) != 0;
        if (mode == 1 && !ready) scnt++;
        bus.plane_ready = ready;
        held = !ready;
        pidx = bus.plane_idx;
        pwp = bus.wl_p;
        pwn = bus.wl_n;
        if (ready) begin
          nplanes++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else stalls++;
        if (chg && bus.plane_idx == 4'd1) bus.input_bits = 4'd8;
        if (mode == 2) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.bipolar_p = (NL * IB)'($urandom);
          bus.bipolar_n = (NL * IB)'($urandom);
        end
        step;
      end
    end
    bus.in_valid = 1'b0;
    bus.plane_ready = 1'b1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stream_timeout: in_ready=%b after 200 cycles, required 1", bus.in_ready);
    end
  endtask
  task automatic test_reset;
    nrst = 1'b0;
    step;
    step;
    checks++;
    if ({bus.in_ready, bus.plane_valid, bus.busy, bus.plane_last, bus.wl_p, bus.wl_n, bus.plane_idx} !== '0) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b v=%b busy=%b last=%b p=%b n=%b idx=%0d, required all 0",
               bus.in_ready, bus.plane_valid, bus.busy, bus.plane_last, bus.wl_p, bus.wl_n, bus.plane_idx);
    end
    nrst = 1'b1;
    step;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.plane_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b v=%b, required 1 0 0", bus.in_ready, bus.busy, bus.plane_valid);
    end
  endtask
  task automatic load_basic;
    cur_p = '0;
    cur_n = '0;
    cur_p[0] = 8'd5;
    cur_p[2] = 8'd15;
    cur_n[1] = 8'd3;
  endtask
  task automatic test_basic;
    int np;
    load_basic();
    run_vec(4'd4, 0, 1'b0, np);
    checks++;
    if (np != 4) begin
      errors++;
      $display("FAIL basic_count: planes=%0d required 4", np);
    end
  endtask
  task automatic test_stall;
    int np;
    load_basic();
    run_vec(4'd4, 1, 1'b0, np);
    checks++;
    if (np != 4) begin
      errors++;
      $display("FAIL stall_count: handshakes=%0d required 4", np);
    end
  endtask
  task automatic test_clamp;
    int np;
    cur_p = '0;
    cur_n = '0;
    cur_p[0] = 8'd128;
    cur_p[1] = 8'hFF;
    run_vec(4'd0, 0, 1'b0, np);
    checks++;
    if (np != 8) begin
      errors++;
      $display("FAIL clamp_zero: planes=%0d required 8", np);
    end
    cur_p[1] = 8'd0;
    run_vec(4'd12, 0, 1'b0, np);
    checks++;
    if (np != (SKIP ? 1 : 8)) begin
      errors++;
      $display("FAIL clamp_high: planes=%0d required %0d", np, SKIP ? 1 : 8);
    end
  endtask
  task automatic test_precision_change;
    int np;
    cur_n = '0;
    for (int l = 0; l < NL; l++) cur_p[l] = 8'd7;
    run_vec(4'd3, 0, 1'b1, np);
    checks++;
    if (np != 3) begin
      errors++;
      $display("FAIL precision_change: planes=%0d required 3", np);
    end
  endtask
  task automatic test_zero_skip;
    int np;
    cur_n = '0;
    for (int l = 0; l < NL; l++) cur_p[l] = 8'h41;
    run_vec(4'd8, 0, 1'b0, np);
    checks++;
    if (np != (SKIP ? 3 : 8)) begin
      errors++;
      $display("FAIL zero_skip_count: planes=%0d required %0d", np, SKIP ? 3 : 8);
    end
  endtask
  task automatic test_reset_mid;
    int np;
    bit hit;
    hit = 0;
    cur_n = '0;
    for (int l = 0; l < NL; l++) cur_p[l] = 8'hFF;
    for (int c = 0; c < 20 && !bus.in_ready; c++) step;
    bus.in_valid = 1'b1;
    bus.bipolar_p = cur_p;
    bus.bipolar_n = cur_n;
    bus.input_bits = 4'd8;
    bus.plane_ready = 1'b1;
    step;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      if (bus.plane_idx == 4'd2 && bus.plane_valid === 1'b1) hit = 1;
      else step;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL reset_mid_reach: idx=%0d required 2", bus.plane_idx);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.plane_valid, bus.busy, bus.plane_last, bus.wl_p, bus.wl_n, bus.plane_idx} !== '0) begin
      errors++;
      $display("FAIL reset_async: rdy=%b v=%b busy=%b last=%b p=%b n=%b idx=%0d, required all 0",
               bus.in_ready, bus.plane_valid, bus.busy, bus.plane_last, bus.wl_p, bus.wl_n, bus.plane_idx);
    end
    #1 nrst = 1'b1;
    step;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: rdy=%b busy=%b, required 1 0", bus.in_ready, bus.busy);
    end
    run_vec(4'd8, 0, 1'b0, np);
    checks++;
    if (np != 8) begin
      errors++;
      $display("FAIL reset_mid_restream: planes=%0d required 8", np);
    end
  endtask
  task automatic test_back_to_back;
    int np;
    for (int i = 0; i < 4; i++) begin
      rand_vec();
      run_vec(4'($urandom_range(0, 15)), 0, 1'b0, np);
    end
  endtask
  task automatic test_random;
    int np;
    for (int i = 0; i < 40; i++) begin
      rand_vec();
      run_vec(4'($urandom_range(0, 15)), i % 3 == 0 ? 1 : 2, 1'b0, np);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.plane_ready = 1'b1;
    bus.input_bits = 4'd0;
    bus.bipolar_p = '0;
    bus.bipolar_n = '0;
    cur_p = '0;
    cur_n = '0;
    test_reset();
    test_basic();
    test_stall();
    test_clamp();
    test_precision_change();
    test_zero_skip();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
endmodule
